// File: rtl/axon_spike_scheduler_if.sv
// Handshake bundle between the soma-side producer, the axon spike scheduler and the synapse/router consumer.
// SPIKE_COUNT_EN adds the spike_count signal to the bundle.
interface axon_spike_if #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
);
  localparam int SLOT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PCNT_W = $clog2(DEPTH + 1);

  logic              in_valid;
  logic [15:0]       in_delay;
  logic              in_full;
  logic              out_valid;
  logic              out_ready;
  logic [SLOT_W-1:0] out_slot;
  logic [PCNT_W-1:0] pending_cnt;
  logic              drop;
  logic              overflow;
`ifdef SPIKE_COUNT_EN
  logic [CNT_W-1:0]  spike_count;
`else
  localparam int unused_cnt_w = CNT_W;
`endif

  modport master (
    output in_valid, in_delay, out_ready,
    input  in_full, out_valid, out_slot, pending_cnt, drop, overflow
`ifdef SPIKE_COUNT_EN
    , input spike_count
`endif
  );

  modport slave (
    input  in_valid, in_delay, out_ready,
    output in_full, out_valid, out_slot, pending_cnt, drop, overflow
`ifdef SPIKE_COUNT_EN
    , output spike_count
`endif
  );
endinterface

// File: rtl/axon_spike_scheduler.sv
// Axon delay scheduler: parks each fired spike in a delay slot for its axon delay (in ticks) and
// presents expired spikes lowest-slot-first. Define SPIKE_COUNT_EN to add the delivered-spike counter.
module axon_spike_scheduler #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic tick,
  axon_spike_if.slave bus
);
  localparam int SLOT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PCNT_W = $clog2(DEPTH + 1);

  localparam logic [1:0] S_FREE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_READY = 2'd2;

  // 8.8 delay -> whole ticks, round half up, saturate at 255.
  function automatic logic [7:0] delay_to_ticks(input logic [8:0] dly_int_half);
    logic [8:0] sum;
    sum = {1'b0, dly_int_half[8:1]} + {8'd0, dly_int_half[0]};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  logic [1:0]        state_q [DEPTH];
  logic [1:0]        state_d [DEPTH];
  logic [7:0]        cnt_q   [DEPTH];
  logic [7:0]        cnt_d   [DEPTH];
  logic              drop_q, drop_d;
  logic              overflow_q, overflow_d;

  logic              free_found, rdy_found;
  logic [SLOT_W-1:0] free_idx, rdy_idx;
  logic [PCNT_W-1:0] pend;
  logic [7:0]        in_ticks;
  logic              accept;
  logic              unused_frac;

  assign unused_frac = ^bus.in_delay[6:0];
  assign in_ticks    = delay_to_ticks(bus.in_delay[15:7]);

  // Scanning from the top down leaves the lowest matching index in the result.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    rdy_found  = 1'b0;
    rdy_idx    = '0;
    pend       = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (state_q[i] == S_FREE) begin
        free_found = 1'b1;
        free_idx   = SLOT_W'(i);
      end
      if (state_q[i] == S_READY) begin
        rdy_found = 1'b1;
        rdy_idx   = SLOT_W'(i);
      end
      if (state_q[i] != S_FREE) pend = pend + PCNT_W'(1);
    end
  end

  assign accept = rdy_found & bus.out_ready;

  // Tick, handshake and allocation each only ever touch WAIT, READY and FREE slots respectively.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    drop_d     = 1'b0;
    overflow_d = overflow_q;
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) state_d[i] = S_FREE;
      overflow_d = 1'b0;
    end else begin
      if (tick) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (state_q[i] == S_WAIT) begin
            cnt_d[i] = cnt_q[i] - 8'd1;
            if (cnt_q[i] == 8'd1) state_d[i] = S_READY;
          end
        end
      end
      if (accept) state_d[rdy_idx] = S_FREE;
      if (bus.in_valid) begin
        if (free_found) begin
          state_d[free_idx] = (in_ticks == 8'd0) ? S_READY : S_WAIT;
          cnt_d[free_idx]   = in_ticks;
        end else begin
          drop_d     = 1'b1;
          overflow_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= '{default: S_FREE};
      drop_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      drop_q     <= drop_d;
      overflow_q <= overflow_d;
    end
  end

  // Countdown values are only meaningful while a slot is WAIT, so they carry no reset.
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

`ifdef SPIKE_COUNT_EN
  logic [CNT_W-1:0] spike_count_q, spike_count_d;

  always_comb begin
    spike_count_d = spike_count_q;
    if (clr)         spike_count_d = '0;
    else if (accept) spike_count_d = spike_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) spike_count_q <= '0;
    else      spike_count_q <= spike_count_d;
  end

  assign bus.spike_count = spike_count_q;
`else
  localparam int unused_cnt_w = CNT_W;
`endif

  assign bus.in_full     = ~free_found;
  assign bus.out_valid   = rdy_found;
  assign bus.out_slot    = rdy_idx;
  assign bus.pending_cnt = pend;
  assign bus.drop        = drop_q;
  assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_axon_spike_scheduler.sv
// Randomized and directed bench for axon_spike_scheduler against an absolute-time slot model.
module tb_axon_spike_scheduler;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b0;
  logic tick = 1'b0;

  axon_spike_if #(.DEPTH(DEPTH), .CNT_W(16)) sif ();

  axon_spike_scheduler #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .tick(tick),
    .bus (sif.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Model: a busy slot expires at an absolute tick number; it is ready once time reaches it.
  bit m_busy [DEPTH];
  int m_exp  [DEPTH];
  int tnow;
  bit m_drop, m_ovf;
  int m_cnt;

  function automatic int ticks_of(input logic [15:0] dly);
    int d;
    d = int'(dly) / 256 + ((int'(dly) / 128) % 2);
    return (d > 255) ? 255 : d;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_busy[i] = 0;
    m_drop = 0;
    m_ovf  = 0;
    m_cnt  = 0;
  endtask

  task automatic model_edge(input bit v, input logic [15:0] dly, input bit tk, input bit rdy, input bit cl);
    int fi, ri;
    if (cl) begin
      model_reset();
      tnow += int'(tk);
      return;
    end
    fi = -1;
    ri = -1;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!m_busy[i]) fi = i;
      if (m_busy[i] && tnow >= m_exp[i]) ri = i;
    end
    m_drop = 0;
    if (ri >= 0 && rdy) begin
      m_busy[ri] = 0;
      m_cnt++;
    end
    if (v) begin
      if (fi >= 0) begin
        m_busy[fi] = 1;
        m_exp[fi]  = tnow + int'(tk) + ticks_of(dly);
      end else begin
        m_drop = 1;
        m_ovf  = 1;
      end
    end
    tnow += int'(tk);
  endtask

  task automatic check_outputs(input string ph);
    int ev, es, ep;
    ev = 0;
    es = 0;
    ep = 0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (m_busy[i]) ep++;
      if (m_busy[i] && tnow >= m_exp[i]) begin
        ev = 1;
        es = i;
      end
    end
    check({ph, ".out_valid"}, 32'(sif.out_valid), 32'(ev));
    check({ph, ".out_slot"}, 32'(sif.out_slot), 32'(es));
    check({ph, ".in_full"}, 32'(sif.in_full), 32'(ep == DEPTH));
    check({ph, ".pending_cnt"}, 32'(sif.pending_cnt), 32'(ep));
    check({ph, ".drop"}, 32'(sif.drop), 32'(m_drop));
    check({ph, ".overflow"}, 32'(sif.overflow), 32'(m_ovf));
`ifdef SPIKE_COUNT_EN
    check({ph, ".spike_count"}, 32'(sif.spike_count), 32'(m_cnt % 65536));
`endif
  endtask

  // Entered and left at a negedge: check, drive, clock, update the model.
  task automatic cyc(input bit v, input logic [15:0] dly, input bit tk, input bit rdy, input bit cl,
                     input string ph);
    check_outputs(ph);
    sif.in_valid  = v;
    sif.in_delay  = dly;
    tick          = tk;
    sif.out_ready = rdy;
    clr           = cl;
    @(posedge clk);
    model_edge(v, dly, tk, rdy, cl);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit rdy, input string ph);
    repeat (n) cyc(0, 16'h0000, 0, rdy, 0, ph);
  endtask

  task automatic ticks(input int n, input bit rdy, input string ph);
    repeat (n) cyc(0, 16'h0000, 1, rdy, 0, ph);
  endtask

  logic [15:0] t5_dly [6];

  initial begin
    sif.in_valid  = 0;
    sif.in_delay  = 16'h0000;
    sif.out_ready = 0;
    tnow = 0;
    model_reset();

    #12;
    check("rst.out_valid", 32'(sif.out_valid), 0);
    check("rst.in_full", 32'(sif.in_full), 0);
    check("rst.pending_cnt", 32'(sif.pending_cnt), 0);
    check("rst.overflow", 32'(sif.overflow), 0);
    check("rst.drop", 32'(sif.drop), 0);
    @(negedge clk);
    rst = 1;
    idle(2, 0, "rst");

    // Delay of three whole ticks, consumer always ready.
    cyc(1, 16'h0300, 0, 1, 0, "t2");
    check("t2.pend1", 32'(sif.pending_cnt), 1);
    ticks(2, 1, "t2");
    check("t2.not_yet", 32'(sif.out_valid), 0);
    ticks(1, 1, "t2");
    check("t2.valid", 32'(sif.out_valid), 1);
    check("t2.slot", 32'(sif.out_slot), 0);
    idle(1, 1, "t2");
    check("t2.pend0", 32'(sif.pending_cnt), 0);

    // Rounding and saturation of the 8.8 delay.
    cyc(1, 16'h0280, 0, 0, 0, "t3a");
    ticks(2, 0, "t3a");
    check("t3a.not_yet", 32'(sif.out_valid), 0);
    ticks(1, 0, "t3a");
    check("t3a.valid", 32'(sif.out_valid), 1);
    idle(2, 1, "t3a");
    cyc(1, 16'h0000, 0, 0, 0, "t3b");
    check("t3b.valid", 32'(sif.out_valid), 1);
    idle(2, 1, "t3b");
    cyc(1, 16'hFF80, 0, 0, 0, "t3c");
    ticks(254, 0, "t3c");
    check("t3c.not_yet", 32'(sif.out_valid), 0);
    ticks(1, 0, "t3c");
    check("t3c.valid", 32'(sif.out_valid), 1);
    idle(2, 1, "t3c");

    // Fill every slot, then overflow.
    repeat (DEPTH) cyc(1, 16'h0500, 0, 0, 0, "t4");
    check("t4.full", 32'(sif.in_full), 1);
    check("t4.pend", 32'(sif.pending_cnt), DEPTH);
    cyc(1, 16'h0500, 0, 0, 0, "t4");
    check("t4.drop", 32'(sif.drop), 1);
    check("t4.ovf", 32'(sif.overflow), 1);
    check("t4.pend_hold", 32'(sif.pending_cnt), DEPTH);
    idle(1, 0, "t4");
    check("t4.drop_end", 32'(sif.drop), 0);
    check("t4.ovf_sticky", 32'(sif.overflow), 1);
    cyc(0, 16'h0000, 1, 1, 1, "t4");

    // Slots 2 and 5 expire on the same tick.
    t5_dly = '{16'h0A00, 16'h0A00, 16'h0200, 16'h0A00, 16'h0A00, 16'h0200};
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < 6; i++) cyc(1, t5_dly[i], 0, 0, 0, "t5");
      ticks(2, rep == 0, "t5");
      check("t5.first", 32'(sif.out_slot), 2);
      if (rep == 1) begin
        for (int k = 0; k < 4; k++) begin
          idle(1, 0, "t5hold");
          check("t5.held", 32'(sif.out_slot), 2);
        end
      end
      idle(1, 1, "t5");
      check("t5.second", 32'(sif.out_slot), 5);
      idle(1, 1, "t5");
      check("t5.drained", 32'(sif.out_valid), 0);
      cyc(0, 16'h0000, 0, 0, 1, "t5clr");
    end

    // Synchronous flush of in-flight spikes after an overflow.
    repeat (DEPTH + 1) cyc(1, 16'h0500, 0, 0, 0, "t6");
    cyc(0, 16'h0000, 1, 0, 1, "t6");
    check("t6.clr_pend", 32'(sif.pending_cnt), 0);
    check("t6.clr_ovf", 32'(sif.overflow), 0);

    // Asynchronous reset between clock edges.
    repeat (3) cyc(1, 16'h0000, 0, 0, 0, "t6r");
    sif.in_valid = 0;
    #2 rst = 0;
    #1;
    check("t6r.valid", 32'(sif.out_valid), 0);
    check("t6r.pend", 32'(sif.pending_cnt), 0);
    check("t6r.full", 32'(sif.in_full), 0);
    model_reset();
    @(negedge clk);
    rst = 1;

    // Four deliveries, then a flush.
    repeat (4) cyc(1, 16'h0000, 0, 1, 0, "t6c");
    idle(2, 1, "t6c");
`ifdef SPIKE_COUNT_EN
    check("t6c.count4", 32'(sif.spike_count), 4);
`endif
    cyc(0, 16'h0000, 0, 0, 1, "t6c");
`ifdef SPIKE_COUNT_EN
    check("t6c.count0", 32'(sif.spike_count), 0);
`endif

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] d;
      d = 16'($urandom_range(0, 6) * 256 + $urandom_range(0, 255));
      cyc($urandom_range(0, 2) == 0, d, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
          $urandom_range(0, 199) == 0, "rnd");
    end
    ticks(10, 1, "drain");
    idle(DEPTH + 2, 1, "drain");
    check_outputs("end");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
